// File: rtl/warp_fifo_if.sv
// Ready/valid handshake bundle for warp_fifo: upstream push side, downstream pop
// side and occupancy status.
interface warp_fifo_if #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             i_input_valid;
   logic             o_input_ready;
   logic [WIDTH-1:0] i_input_data;
   logic             o_output_valid;
   logic             i_output_ready;
   logic [WIDTH-1:0] o_output_data;
   logic [CW-1:0]    o_count;
   logic             o_almost_full;

   // FIFO side
   modport slave (
      input  i_input_valid,
      output o_input_ready,
      input  i_input_data,
      output o_output_valid,
      input  i_output_ready,
      output o_output_data,
      output o_count,
      output o_almost_full
   );

   // Producer/consumer side
   modport master (
      output i_input_valid,
      input  o_input_ready,
      output i_input_data,
      input  o_output_valid,
      output i_output_ready,
      input  o_output_data,
      input  o_count,
      input  o_almost_full
   );
endinterface

// File: rtl/warp_fifo.sv
// Synchronous ready/valid FIFO with occupancy count, almost-full flag and flush.
// Handshake behaviour matches warp_skid when DEPTH=2.
module warp_fifo #(
   parameter int unsigned WIDTH       = 1,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_flush,
   warp_fifo_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   logic             not_full;
   logic             not_empty;
   logic             push;
   logic             pop;

   // Flags come from the registered count only, never from the partner's handshake.
   always_comb begin
      not_full  = (count != FULL_CNT);
      not_empty = (count != '0);
      push      = bus.i_input_valid && not_full;
      pop       = not_empty && bus.i_output_ready;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately not reset; writes are suppressed during reset/flush.
   always_ff @(posedge i_clk) begin
      if (push && !i_rst && !i_flush) begin
         mem[wr_ptr] <= bus.i_input_data;
      end
   end

   always_comb begin
      bus.o_input_ready  = not_full;
      bus.o_output_valid = not_empty;
      bus.o_count        = count;
      bus.o_almost_full  = (count >= AFULL_CNT);
      bus.o_output_data  = not_empty ? mem[rd_ptr] : '0;
   end
endmodule

// File: tb/tb_warp_fifo.sv
// Directed and randomised self-checking bench for warp_fifo (WIDTH=8, DEPTH=4,
// AFULL_LEVEL=3) against a reference queue.
module tb_warp_fifo;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned AFULL = 3;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   warp_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   warp_fifo #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .AFULL_LEVEL (AFULL)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input int unsigned cnt, input logic [7:0] head);
      check({tag, "_count"}, 32'(bus.o_count), cnt);
      check({tag, "_ready"}, 32'(bus.o_input_ready), 32'(cnt != DEPTH));
      check({tag, "_valid"}, 32'(bus.o_output_valid), 32'(cnt != 0));
      check({tag, "_afull"}, 32'(bus.o_almost_full), 32'(cnt >= AFULL));
      check({tag, "_data"}, 32'(bus.o_output_data), (cnt != 0) ? 32'(head) : 32'd0);
   endtask

   logic [7:0] model_q [$];
   logic [7:0] push_vec [5];

   initial begin
      logic       hold;
      logic       do_push;
      logic       do_pop;
      logic       do_rst;
      logic       do_flush;

      push_vec[0] = 8'h11;
      push_vec[1] = 8'h22;
      push_vec[2] = 8'h33;
      push_vec[3] = 8'h44;
      push_vec[4] = 8'h55;

      rst                = 1'b1;
      flush              = 1'b0;
      bus.i_input_valid  = 1'b0;
      bus.i_input_data   = '0;
      bus.i_output_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset then idle
      for (int i = 0; i < 10; i++) begin
         check_state("idle", 0, 8'h00);
         tick();
      end

      // Fill to full with downstream stalled
      for (int i = 0; i < 4; i++) begin
         bus.i_input_valid = 1'b1;
         bus.i_input_data  = push_vec[i];
         tick();
         check_state("fill", i + 1, 8'h11);
      end

      // Fifth word offered while full must be held off
      bus.i_input_data = 8'h55;
      tick();
      check_state("full_hold", 4, 8'h11);

      // One-cycle pop from full: no pass-through, 0x55 enters the cycle after
      bus.i_output_ready = 1'b1;
      tick();
      bus.i_output_ready = 1'b0;
      check_state("pop_from_full", 3, 8'h22);
      tick();
      bus.i_input_valid = 1'b0;
      check_state("refill", 4, 8'h22);

      bus.i_output_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check("drain_data", 32'(bus.o_output_data), 32'(push_vec[i]));
         tick();
      end
      bus.i_output_ready = 1'b0;
      check_state("drained", 0, 8'h00);

      // Streaming at one transfer per cycle
      bus.i_input_valid  = 1'b1;
      bus.i_output_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         bus.i_input_data = 8'(k);
         if (k > 0) begin
            check("stream_data", 32'(bus.o_output_data), 32'(k - 1));
            check("stream_count", 32'(bus.o_count), 32'd1);
         end
         tick();
      end
      bus.i_input_valid = 1'b0;
      check_state("stream_tail", 1, 8'd19);
      tick();
      bus.i_output_ready = 1'b0;
      check_state("stream_done", 0, 8'h00);

      // Flush with a concurrent push
      bus.i_input_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.i_input_data = 8'(i + 1);
         tick();
      end
      check_state("pre_flush", 3, 8'h01);
      bus.i_input_data = 8'hAA;
      flush            = 1'b1;
      tick();
      flush             = 1'b0;
      bus.i_input_valid = 1'b0;
      check_state("flushed", 0, 8'h00);
      bus.i_input_valid = 1'b1;
      bus.i_input_data  = 8'hBB;
      tick();
      bus.i_input_valid = 1'b0;
      check_state("post_flush", 1, 8'hBB);
      bus.i_output_ready = 1'b1;
      tick();
      bus.i_output_ready = 1'b0;
      check_state("post_flush_empty", 0, 8'h00);

      // Random traffic against a reference queue, with sporadic reset and flush
      model_q.delete();
      hold = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         if (!hold) begin
            bus.i_input_valid = 1'($urandom_range(0, 1));
            bus.i_input_data  = 8'($urandom);
         end
         bus.i_output_ready = 1'($urandom_range(0, 1));
         do_rst   = ($urandom_range(0, 199) == 0);
         do_flush = ($urandom_range(0, 149) == 0);
         rst   = do_rst;
         flush = do_flush;

         check_state("rand", model_q.size(), (model_q.size() != 0) ? model_q[0] : 8'h00);

         do_push = bus.i_input_valid && (model_q.size() != DEPTH);
         do_pop  = bus.i_output_ready && (model_q.size() != 0);
         hold    = bus.i_input_valid && !do_push;
         tick();

         if (do_rst || do_flush) begin
            model_q.delete();
         end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(bus.i_input_data);
         end
      end
      rst   = 1'b0;
      flush = 1'b0;
      check_state("rand_end", model_q.size(), (model_q.size() != 0) ? model_q[0] : 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
